// File: rtl/response_transmitter_pkg.sv
// Shared types for the response transmitter: FSM state encoding and default checksum seed.
// The checksum states only exist when RESP_CHECKSUM_EN is defined.
package response_transmitter_pkg;

    localparam logic [7:0] DEFAULT_CHECKSUM_SEED = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2
`ifdef RESP_CHECKSUM_EN
        ,
        ST_CHK_START = 3'd3,
        ST_CHK_WAIT  = 3'd4
`endif
    } state_t;

`ifdef RESP_CHECKSUM_EN
    // Running XOR checksum over the bytes of one response pair.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction
`endif

endpackage

// File: rtl/response_transmitter_if.sv
// Handshake bundle between the response handler / UART_TX side (master) and the transmitter (slave).
interface response_transmitter_if;
    logic       response_ready;
    logic [7:0] response;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       pair_sent;
    logic       overflow;
    logic       idle;

    modport master (
        output response_ready, response, tx_busy, tx_done,
        input  tx_start, tx_data, pair_sent, overflow, idle
    );

    modport slave (
        input  response_ready, response, tx_busy, tx_done,
        output tx_start, tx_data, pair_sent, overflow, idle
    );
endinterface

// File: rtl/response_transmitter_byte_fifo.sv
// Power-of-two byte FIFO; a push while full is accepted only when a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= din;
    end
endmodule

// File: rtl/response_transmitter.sv
// Buffers response bytes and feeds them pairwise (type, data) to UART_TX via a start/done handshake.
// Define RESP_CHECKSUM_EN to append an XOR checksum byte after every pair.
module response_transmitter
    import response_transmitter_pkg::*;
#(
    parameter int         FIFO_DEPTH    = 4,
    parameter logic [7:0] CHECKSUM_SEED = DEFAULT_CHECKSUM_SEED
) (
    input  logic                  clock,
    input  logic                  reset,
    response_transmitter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_r;
    state_t        state_next_s;
    logic          phase_r;
    logic          tx_start_r;
    logic [7:0]    tx_data_r;
    logic          pair_sent_r;
    logic          overflow_r;
    logic          idle_r;
    logic          pop_s;
    logic          start_s;
    logic [7:0]    start_byte_s;
    logic          pair_done_s;
    logic          push_acc_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [7:0]    fifo_dout_s;
    logic [CW-1:0] fifo_count_s;
    logic [CW-1:0] count_nxt_s;
`ifdef RESP_CHECKSUM_EN
    logic [7:0]    acc_r;
`endif

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (bus.response_ready),
        .pop   (pop_s),
        .din   (bus.response),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Predicted FIFO occupancy after this edge, so idle can be registered without lag.
    assign push_acc_s  = bus.response_ready && (!fifo_full_s || pop_s);
    assign count_nxt_s = fifo_count_s + CW'(push_acc_s) - CW'(pop_s);

    // Next-state and per-state strobes.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        start_s      = 1'b0;
        start_byte_s = fifo_dout_s;
        pair_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && !bus.tx_busy) state_next_s = ST_START;
                else                               state_next_s = ST_IDLE;
            end
            ST_START: begin
                pop_s        = 1'b1;
                start_s      = 1'b1;
                start_byte_s = fifo_dout_s;
                state_next_s = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
`ifdef RESP_CHECKSUM_EN
                    if (phase_r) state_next_s = ST_CHK_START;
                    else         state_next_s = ST_IDLE;
`else
                    pair_done_s  = phase_r;
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    state_next_s = ST_WAIT_DONE;
                end
            end
`ifdef RESP_CHECKSUM_EN
            ST_CHK_START: begin
                start_s      = 1'b1;
                start_byte_s = acc_r;
                state_next_s = ST_CHK_WAIT;
            end
            ST_CHK_WAIT: begin
                if (bus.tx_done) begin
                    pair_done_s  = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CHK_WAIT;
                end
            end
`endif
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            phase_r     <= 1'b0;
            tx_start_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            pair_sent_r <= 1'b0;
            overflow_r  <= 1'b0;
            idle_r      <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            tx_start_r  <= start_s;
            pair_sent_r <= pair_done_s;
            if (start_s) tx_data_r <= start_byte_s;
            if ((state_r == ST_WAIT_DONE) && bus.tx_done) phase_r <= ~phase_r;
            overflow_r  <= overflow_r | (bus.response_ready && fifo_full_s && !pop_s);
            idle_r      <= (state_next_s == ST_IDLE) && (count_nxt_s == {CW{1'b0}});
        end
    end

`ifdef RESP_CHECKSUM_EN
    // Checksum accumulator: folds each popped byte, reloads once the checksum frame completes.
    always_ff @(posedge clock) begin
        if (reset)            acc_r <= CHECKSUM_SEED;
        else if (pop_s)       acc_r <= chk_fold(acc_r, fifo_dout_s);
        else if (pair_done_s) acc_r <= CHECKSUM_SEED;
    end
`endif

    assign bus.tx_start  = tx_start_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.pair_sent = pair_sent_r;
    assign bus.overflow  = overflow_r;
    assign bus.idle      = idle_r;
endmodule

// File: doc/response_transmitter.md
RESPONSE_TRANSMITTER -- requirements
Module: response_transmitter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, byte-buffer depth (power of two, 2..16).
REQ-002 SHALL have parameter CHECKSUM_SEED, default 8'h00, initial XOR accumulator value per response pair.
REQ-003 SHALL have port clock  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port response_ready  in  1  one-cycle strobe from the response handler; response byte valid.
REQ-006 SHALL have port response  in  8  response byte; first of pair = type code, second = data.
REQ-007 SHALL have port tx_busy  in  1  UART_TX is shifting a frame.
REQ-008 SHALL have port tx_done  in  1  one-cycle UART_TX end-of-frame strobe.
REQ-009 SHALL have port tx_start  out  1  one-cycle request to UART_TX to send tx_data.
REQ-010 SHALL have port tx_data  out  8  byte for UART_TX; stable from tx_start until tx_done.
REQ-011 SHALL have port pair_sent  out  1  one-cycle strobe after the last frame of a response pair completes.
REQ-012 SHALL have port overflow  out  1  sticky; a byte was dropped because the FIFO was full.
REQ-013 SHALL have port idle  out  1  high when FIFO empty and FSM in IDLE.

Function
REQ-014 SHALL write response into the FIFO on a clock edge where response_ready=1 and FIFO not full.
REQ-015 SHALL drop the byte and set overflow when response_ready=1, FIFO full and no pop that cycle; simultaneous push and pop on full SHALL accept the byte with count unchanged.
REQ-016 SHALL implement FSM states IDLE, START, WAIT_DONE, and, with checksum enabled, CHK_START and CHK_WAIT.
REQ-017 IDLE -> START when FIFO not empty and tx_busy=0; otherwise remain in IDLE.
REQ-018 In START, SHALL assert tx_start for exactly one cycle, load tx_data from FIFO head, pop the FIFO, and go to WAIT_DONE.
REQ-019 WAIT_DONE SHALL hold until tx_done=1, then toggle a byte-phase bit (0=type, 1=data) and return to IDLE, or go to CHK_START when phase was 1 and checksum is enabled.
REQ-020 SHALL produce tx_start two cycles after response_ready is sampled, when the FIFO is empty, the FSM is in IDLE and tx_busy=0.
REQ-021 SHALL pulse pair_sent in the cycle after tx_done of the data byte, or of the checksum byte when checksum is enabled.
REQ-022 SHALL use FIFO read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, and a count of log2(FIFO_DEPTH)+1 bits.
REQ-023 SHALL ignore tx_done in every state except WAIT_DONE and CHK_WAIT.

Reset
REQ-024 Reset SHALL force: FSM=IDLE, pointers/count=0, phase=0, tx_start=0, tx_data=8'h00, pair_sent=0, overflow=0, idle=1, accumulator=CHECKSUM_SEED.
REQ-025 Reset asserted mid-frame SHALL abandon the current pair; a later tx_done SHALL be ignored.
REQ-026 Reset SHALL take priority over simultaneous response_ready.

Configuration
REQ-027 Macro RESP_CHECKSUM_EN defined: after each pair SHALL send a third byte = CHECKSUM_SEED XOR type XOR data via CHK_START/CHK_WAIT, with the same tx_start/tx_done handshake; accumulator reloads CHECKSUM_SEED after the checksum byte is sent.
REQ-028 RESP_CHECKSUM_EN undefined: SHALL send only two bytes per pair; no checksum states or accumulator logic present.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding constants and the default CHECKSUM_SEED.
REQ-030 SHALL contain one sub-module, byte_fifo (parameterised depth, push/pop/full/empty/count).

Verification
REQ-031 Push 8'h12, 8'h1A with UART idle and tx_done 10 cycles after each tx_start -> tx_data 8'h12 then 8'h1A, one pair_sent.
REQ-032 With RESP_CHECKSUM_EN defined and SEED 8'h00, pair 8'h13, 8'h25 -> third byte 8'h36, then pair_sent.
REQ-033 Hold tx_busy=1 and push 5 bytes with FIFO_DEPTH=4 -> 5th byte dropped, overflow=1, 4 bytes later sent in order.
REQ-034 Push and pop on the same cycle with FIFO full -> no overflow, count stays 4.
REQ-035 Assert reset during WAIT_DONE, then pulse tx_done -> no pair_sent, idle=1, outputs at reset values.
REQ-036 Push 6 pairs back-to-back with FIFO_DEPTH=4 and a fast UART -> all 12 bytes sent in order across pointer wrap.
